digit_scan_mux: RTL
===================

// Module: digit_scan_mux
// PURPOSE
//  Upstream feeder of the seven-segment decoder in the Two4DigitDisplay design.
//  Holds two 4-digit hex values (8 nibbles), time-multiplexes them onto one shared
//  nibble bus, and drives the matching active-low anode enable per refresh slot.
//  Adds leading-zero blanking per 4-digit group, anti-ghost guard time and
//  load-gated input snapshots.
// PARAMETERS
//  REFRESH_DIV   100000  clocks per digit slot (>=2); prescaler width $clog2(REFRESH_DIV)
//  GUARD_CYCLES  2       clocks at slot start with all anodes off (0 <= GUARD_CYCLES < REFRESH_DIV)
//  BLANK_EN      1       1 = leading-zero blanking enabled; 0 = all 8 digits always lit
// PORTS
//  Clk          in   1   system clock, rising edge
//  Rst          in   1   asynchronous reset, active-high
//  Load         in   1   1-cycle strobe: capture NumberLeft/NumberRight/DpIn into snapshot
//  NumberLeft   in   16  left group, digits 7..4 ([15:12] = digit 7)
//  NumberRight  in   16  right group, digits 3..0 ([3:0] = digit 0)
//  DpIn         in   8   decimal point request per digit, 1 = lit
//  numout       out  4   nibble of current digit, feeds decoder numin
//  an           out  8   anode enables, active-low, an[i] = digit i
//  dp           out  1   decimal point, active-low
//  slot_tick    out  1   high for exactly the first cycle of every slot
// BEHAVIOUR
//  Reset (async, immediate): snapshot=0, cnt=0, idx=0, numout=4'h0, an=8'hFF, dp=1,
//   slot_tick=0. First slot after release shows digit 0; slot_tick first high when cnt==0
//   of slot 1 (i.e. REFRESH_DIV cycles after release). Reset mid-scan abandons slot.
//  Prescaler cnt: 0..REFRESH_DIV-1, wraps to 0; on wrap idx <= idx+1 (7 wraps to 0).
//  numout/dp/blank state registered at the slot boundary edge from the snapshot value
//   present BEFORE that edge; constant for the whole slot.
//  an: 8'hFF while cnt < GUARD_CYCLES; else ~(8'b1 << idx), or 8'hFF if digit blanked.
//  dp: 0 only when an[idx]==0 and snapshot DpIn[idx]==1; else 1.
//  Blanking (BLANK_EN=1): digit k of a group blanked iff it and every more-significant
//   digit of same group are 4'h0; digit 0 and digit 4 never blanked. Groups independent.
//  Load: snapshot updated on the edge Load is sampled high; Load=0 -> inputs ignored.
//   Load on the same edge as a slot boundary: that boundary uses old snapshot; new data
//   visible from the following boundary. Back-to-back Loads: last one wins.
//  Slot latency: Load to visible on digit i <= 9 slots worst case.
//  No handshake back-pressure; decoder is purely combinational downstream.
// STRUCTURE
//  display_pkg: NUM_DIGITS=8, DIGITS_PER_GROUP=4, AN_ALL_OFF=8'hFF, nibble_t typedef.
//  Sub-module lead_zero_mask (16-bit group -> 4-bit blank mask), instantiated twice.
//  Top holds prescaler, idx counter, snapshot regs, output regs.
// TESTING (bench uses REFRESH_DIV=4, GUARD_CYCLES=1)
//  1 Rst asserted while idx=5, mid-slot -> same-cycle an=8'hFF, numout=0, dp=1;
//    after release next slots run idx 0,1,2 in order.
//  2 Load L=16'h12AB, R=16'h0000, BLANK_EN=1 -> slot0 numout=0 an=8'hFE; slots1-3
//    an=8'hFF; slots4..7 numout B,A,2,1 with an[4..7] low in turn.
//  3 Guard/tick: each slot cnt0 an=8'hFF, cnt1-3 one anode low; slot_tick every 4th clk.
//  4 Load R=16'h0005 on a boundary edge (old R=16'h0009) -> that slot digit0 shows 9,
//    next pass shows 5.
//  5 Change inputs with Load=0 for 40 cycles -> numout/an sequence unchanged.
//  6 Load DpIn=8'b1000_0001, L=R=16'hFFFF -> dp=0 only in active part of slots 0 and 7;
//    idx wraps 7->0 without skip.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the 8-digit scan multiplexer.
package display_pkg;
    localparam int NUM_DIGITS       = 8;
    localparam int DIGITS_PER_GROUP = 4;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    typedef logic [3:0] nibble_t;

    // Nibble k of the packed 8-digit word (digit 0 in bits [3:0]).
    function automatic nibble_t digit_of(input logic [31:0] word, input logic [2:0] k);
        return word[{k, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/lead_zero_mask.sv
// Leading-zero blank mask for one 4-digit group; bit 3 is the most significant digit.
// The least significant digit of a group is never blanked.
module lead_zero_mask
    import display_pkg::*;
(
    input  logic [15:0] digits,
    input  logic        enable,
    output logic [3:0]  mask
);
    logic z3, z2, z1;

    assign z3 = enable && (digits[15:12] == 4'h0);
    assign z2 = z3 && (digits[11:8] == 4'h0);
    assign z1 = z2 && (digits[7:4] == 4'h0);

    assign mask = {z3, z2, z1, 1'b0};
endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexes two 4-digit hex groups onto one nibble bus with active-low anodes,
// guard time at each slot start, leading-zero blanking and load-gated input snapshots.
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2,
    parameter bit BLANK_EN     = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] NumberLeft,
    input  logic [15:0] NumberRight,
    input  logic [7:0]  DpIn,
    output logic [3:0]  numout,
    output logic [7:0]  an,
    output logic        dp,
    output logic        slot_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_W = CW'(GUARD_CYCLES);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   snap_num;
    logic [7:0]    snap_dp;
    logic          blank_q;
    logic          dp_bit_q;

    logic [7:0]    blank_vec;
    logic          wrap;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx_nxt;
    logic          blank_nxt;
    logic          dp_bit_nxt;
    logic          active_nxt;

    lead_zero_mask u_mask_left (
        .digits (snap_num[31:16]),
        .enable (BLANK_EN),
        .mask   (blank_vec[7:4])
    );

    lead_zero_mask u_mask_right (
        .digits (snap_num[15:0]),
        .enable (BLANK_EN),
        .mask   (blank_vec[3:0])
    );

    // Outputs are registered from next-state values so they change on the same edge as cnt/idx.
    always_comb begin
        wrap       = (cnt == LAST);
        cnt_nxt    = wrap ? '0 : cnt + 1'b1;
        idx_nxt    = wrap ? idx + 3'd1 : idx;
        blank_nxt  = wrap ? blank_vec[idx_nxt] : blank_q;
        dp_bit_nxt = wrap ? snap_dp[idx_nxt] : dp_bit_q;
        active_nxt = (cnt_nxt >= GUARD_W) && !blank_nxt;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt       <= '0;
            idx       <= 3'd0;
            snap_num  <= 32'h0;
            snap_dp   <= 8'h00;
            blank_q   <= 1'b0;
            dp_bit_q  <= 1'b0;
            numout    <= 4'h0;
            an        <= AN_ALL_OFF;
            dp        <= 1'b1;
            slot_tick <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            blank_q   <= blank_nxt;
            dp_bit_q  <= dp_bit_nxt;
            slot_tick <= wrap;
            // Slot content comes from the snapshot as it stood before this edge.
            if (wrap) begin
                numout <= digit_of(snap_num, idx_nxt);
            end
            an <= active_nxt ? ~(8'b1 << idx_nxt) : AN_ALL_OFF;
            dp <= ~(active_nxt & dp_bit_nxt);
            if (Load) begin
                snap_num <= {NumberLeft, NumberRight};
                snap_dp  <= DpIn;
            end
        end
    end
endmodule
